// File: rtl/qam_pkg.sv
// Shared state encoding, default burst framing and preamble bit selection
// for the QAM transmit controller.
package qam_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_PREAMBLE = 2'd1,
        ST_PAYLOAD  = 2'd2,
        ST_FLUSH    = 2'd3
    } state_t;

    localparam int          PRE_LEN_DEF   = 32;
    localparam logic [31:0] PRE_PAT_DEF   = 32'hCCCC_CCCC;
    localparam int          FLUSH_LEN_DEF = 64;
    localparam int          BYTE_BITS     = 8;

    // Preamble bit k is taken from the top of the pattern, MSB first.
    function automatic logic pre_bit(input logic [31:0] pat, input logic [4:0] k);
        return pat[5'd31 - k];
    endfunction

endpackage

// File: rtl/qam_tx_shreg.sv
// 8-bit payload shift register: parallel load, shift left, MSB is the serial bit.
module qam_tx_shreg
    import qam_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load,
    input  logic                 shift,
    input  logic [BYTE_BITS-1:0] din,
    output logic                 msb
);

    logic [BYTE_BITS-1:0] sr;

    // Load wins over shift so the next byte lands on the last bit of the previous one.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sr <= '0;
        end else if (load) begin
            sr <= din;
        end else if (shift) begin
            sr <= {sr[BYTE_BITS-2:0], 1'b0};
        end
    end

    assign msb = sr[BYTE_BITS-1];

endmodule

// File: rtl/qam_tx_ctrl.sv
// Burst framer for the QAM transmit chain: preamble, payload bytes MSB first,
// then zero flush bits, with underrun detection on the byte handshake.
module qam_tx_ctrl
    import qam_pkg::*;
#(
    parameter int          PRE_LEN   = PRE_LEN_DEF,
    parameter logic [31:0] PRE_PAT   = PRE_PAT_DEF,
    parameter int          FLUSH_LEN = FLUSH_LEN_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] len,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    output logic       s_ready,
    output logic       en,
    output logic       Bin,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    localparam logic [7:0] PRE_LAST   = 8'(PRE_LEN - 1);
    localparam logic [7:0] FLUSH_LAST = 8'(FLUSH_LEN - 1);
    localparam logic [7:0] BYTE_LAST  = 8'(BYTE_BITS - 1);

    state_t     state;
    logic [7:0] bit_cnt;
    logic [7:0] byte_cnt;
    logic [7:0] len_q;
    logic       last_pre;
    logic       last_bit;
    logic       last_byte;
    logic       load;
    logic       shift;
    logic       sr_msb;

    assign last_pre  = (state == ST_PREAMBLE) && (bit_cnt == PRE_LAST);
    assign last_bit  = (state == ST_PAYLOAD) && (bit_cnt == BYTE_LAST);
    assign last_byte = (byte_cnt == len_q - 8'd1);
    assign s_ready   = last_pre || (last_bit && !last_byte);
    assign load      = s_ready && s_valid;
    assign shift     = (state == ST_PAYLOAD);

    qam_tx_shreg u_shreg (
        .clk   (clk),
        .reset (reset),
        .load  (load),
        .shift (shift),
        .din   (s_data),
        .msb   (sr_msb)
    );

    // Outputs trail the state by one cycle; done fires on the first IDLE cycle
    // whose output register still shows the last flush bit (en still high).
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            bit_cnt  <= '0;
            byte_cnt <= '0;
            len_q    <= '0;
            en       <= 1'b0;
            Bin      <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            underrun <= 1'b0;
        end else begin
            en   <= (state != ST_IDLE);
            busy <= (state != ST_IDLE);
            done <= (state == ST_IDLE) && en;
            Bin  <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start && (len != 8'd0)) begin
                        state    <= ST_PREAMBLE;
                        len_q    <= len;
                        underrun <= 1'b0;
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                    end
                end
                ST_PREAMBLE: begin
                    Bin <= pre_bit(PRE_PAT, bit_cnt[4:0]);
                    if (bit_cnt == PRE_LAST) begin
                        bit_cnt  <= '0;
                        byte_cnt <= '0;
                        if (s_valid) begin
                            state <= ST_PAYLOAD;
                        end else begin
                            underrun <= 1'b1;
                            state    <= ST_FLUSH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                ST_PAYLOAD: begin
                    Bin <= sr_msb;
                    if (bit_cnt == BYTE_LAST) begin
                        bit_cnt <= '0;
                        if (last_byte) begin
                            state <= ST_FLUSH;
                        end else if (s_valid) begin
                            byte_cnt <= byte_cnt + 8'd1;
                        end else begin
                            underrun <= 1'b1;
                            state    <= ST_FLUSH;
                        end
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                ST_FLUSH: begin
                    if (bit_cnt == FLUSH_LAST) begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + 8'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/qam_tx_ctrl.md
QAM_TX_CTRL -- requirements
Module: qam_tx_ctrl

Interface
REQ-001 Parameter PRE_LEN, default 32, meaning preamble length in bits (even, 2..32).
REQ-002 Parameter PRE_PAT, default 32'hCCCC_CCCC, meaning the preamble bit pattern; the top PRE_LEN bits are sent MSB first.
REQ-003 Parameter FLUSH_LEN, default 64, meaning zero bits appended after the payload to drain the pulse-shaping filter (even, 2..255).
REQ-004 Port clk, input, 1 bit: bit clock, rising edge; the single clock of the block.
REQ-005 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 Port start, input, 1 bit: burst request, sampled only in IDLE.
REQ-007 Port len, input, 8 bits: payload byte count, sampled with start; 0 is illegal and ignored.
REQ-008 Port s_data, input, 8 bits: payload byte.
REQ-009 Port s_valid, input, 1 bit: s_data is valid.
REQ-010 Port s_ready, output, 1 bit: the controller accepts s_data this cycle.
REQ-011 Port en, output, 1 bit: enable to the QAM transmit chain; high for the whole burst.
REQ-012 Port Bin, output, 1 bit: serial bit to the QAM transmit chain.
REQ-013 Port busy, output, 1 bit: high whenever state is not IDLE.
REQ-014 Port done, output, 1 bit: one-cycle pulse at burst end.
REQ-015 Port underrun, output, 1 bit: sticky error flag, cleared by the next accepted start.

Function
REQ-016 The FSM SHALL have states IDLE, PREAMBLE, PAYLOAD and FLUSH; en, Bin, busy and done SHALL be registered.
REQ-017 IDLE SHALL move to PREAMBLE when start=1 and len!=0; the same edge SHALL latch len, clear underrun, and load bit_cnt=0.
REQ-018 Latency: with start accepted at edge N, en=1 and Bin=PRE_PAT[31] SHALL appear after edge N+1.
REQ-019 PREAMBLE SHALL output preamble bit k on cycle k (k=0..PRE_LEN-1).
REQ-020 s_ready SHALL be high, combinationally, on the last preamble cycle and on bit 7 of every payload byte except the last one.
REQ-021 In any s_ready cycle, s_valid=1 SHALL load s_data into the shift register; the next state SHALL be PAYLOAD.
REQ-022 In any s_ready cycle, s_valid=0 SHALL set underrun; the next state SHALL be FLUSH.
REQ-023 PAYLOAD SHALL output each byte MSB first, one bit per cycle, with no gap between bytes.
REQ-024 After bit 0 of byte len-1, the FSM SHALL enter FLUSH.
REQ-025 FLUSH SHALL drive Bin=0 and en=1 for exactly FLUSH_LEN cycles, then return to IDLE.
REQ-026 The cycle after FLUSH SHALL show en=0, busy=0, Bin=0 and done=1 for exactly one cycle.
REQ-027 start SHALL be ignored in every state except IDLE; s_valid SHALL be ignored whenever s_ready=0.
REQ-028 A burst length SHALL always be an even number of bits, so the downstream S/P pairing is never split.
REQ-029 Counter widths: bit_cnt 8 bits, byte_cnt 8 bits; len=255 SHALL work without wrap.
REQ-030 A start arriving in the same cycle as done SHALL be accepted, because the FSM is in IDLE then.

Reset
REQ-031 reset=0 SHALL asynchronously force state IDLE, en=0, Bin=0, busy=0, done=0, underrun=0, and all counters and the shift register to 0.
REQ-032 If reset is asserted mid-burst, the burst SHALL be abandoned and no done pulse SHALL follow.
REQ-033 Release of reset SHALL be synchronous to clk; the first start SHALL be accepted on the first edge after release.

Structure
REQ-034 The FSM state encoding and the PRE_LEN/FLUSH_LEN defaults SHALL live in a shared package qam_pkg.
REQ-035 One sub-module, qam_tx_shreg (an 8-bit load/shift register, MSB out), is permitted; the counters SHALL stay inline.

Verification
REQ-036 Scenario: start with len=1, s_data=8'hA5, s_valid tied to 1 -> en high for 32+8+64=104 cycles; Bin = CCCCCCCC, then 10100101, then 64 zeros; done pulse 105 cycles after start.
REQ-037 Scenario: len=3, bytes 00/FF/81 supplied exactly on s_ready -> three s_ready pulses spaced 8 cycles apart; payload bits contiguous.
REQ-038 Scenario: len=2, s_valid=0 at the second s_ready -> underrun=1, 64 flush zeros, done pulse; underrun stays set until the next start.
REQ-039 Scenario: reset pulled low at payload bit 3 -> en=0 and Bin=0 immediately; no done pulse; a fresh burst afterwards runs normally.
REQ-040 Scenario: start held high continuously, len=1 -> back-to-back bursts; the second preamble begins the cycle after done.
REQ-041 Scenario: start with len=0 -> stays IDLE, busy=0, en=0.
